rob_commit: RTL and testbench

- In-order commit buffer that sits directly upstream of the register file and drives its single write port.
- Decode allocates an entry per destination-writing instruction, in program order.
- Execution units report results out of order, by tag.
- The block retires results strictly in allocation order, at most one per cycle, onto the regfile write port (write enable, address, data).

---
 rtl/rob_commit.sv | 110 +++++++++++
 tb/tb_rob_commit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rob_commit
// Description : In-order commit buffer feeding the single regfile write port.
//               Results complete out of order by tag and retire in order.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_commit #(
  parameter int DEPTH = 8,
  parameter int TAGW  = 3
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            flush_in,
  input  logic            alloc_valid,
  input  logic [4:0]      alloc_rd,
  output logic            alloc_ready,
  output logic [TAGW-1:0] alloc_tag,
  input  logic            cmpl_valid,
  input  logic [TAGW-1:0] cmpl_tag,
  input  logic [31:0]     cmpl_data,
  output logic            write_or_not,
  output logic [4:0]      writeaddr,
  output logic [31:0]     writedata,
  output logic [TAGW:0]   count_out,
  output logic            empty_out
);

  localparam logic [TAGW:0] c_FULL_COUNT = (TAGW+1)'(DEPTH);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_done;
  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [TAGW-1:0]  r_head;
  logic [TAGW-1:0]  r_tail;
  logic [TAGW:0]    r_count;
  logic             r_write_en;
  logic [4:0]       r_write_addr;
  logic [31:0]      r_write_data;

  logic w_alloc_fire;
  logic w_cmpl_fire;
  logic w_commit_fire;

  assign alloc_ready   = (r_count < c_FULL_COUNT);
  assign alloc_tag     = r_tail;
  assign w_alloc_fire  = alloc_valid && alloc_ready;
  // The allocating slot is still invalid here, so a same-tag completion drops.
  assign w_cmpl_fire   = cmpl_valid && r_valid[cmpl_tag] && !r_done[cmpl_tag];
  assign w_commit_fire = r_valid[r_head] && r_done[r_head];

  assign write_or_not = r_write_en;
  assign writeaddr    = r_write_addr;
  assign writedata    = r_write_data;
  assign count_out    = r_count;
  assign empty_out    = (r_count == '0);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_valid      <= '0;
      r_done       <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
    end else if (flush_in) begin
      r_valid    <= '0;
      r_done     <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_write_en <= 1'b0;
    end else begin
      // Head and tail only coincide when empty or full, so these never collide.
      if (w_alloc_fire) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_tail          <= r_tail + TAGW'(1);
      end
      if (w_cmpl_fire) begin
        r_done[cmpl_tag] <= 1'b1;
      end
      if (w_commit_fire) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_head          <= r_head + TAGW'(1);
        r_write_addr    <= r_rd[r_head];
        r_write_data    <= r_data[r_head];
      end
      r_write_en <= w_commit_fire && (r_rd[r_head] != 5'd0);
      r_count    <= r_count + (TAGW+1)'(w_alloc_fire) - (TAGW+1)'(w_commit_fire);
    end
  end

  // Payload storage is qualified by the valid/done bits and needs no reset.
  always_ff @(posedge clk_in) begin
    if (w_alloc_fire) begin
      r_rd[r_tail] <= alloc_rd;
    end
    if (w_cmpl_fire) begin
      r_data[cmpl_tag] <= cmpl_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_commit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rob_commit
// Description : Scoreboard bench for rob_commit: allocations queue expected
//               writes, completions fill them, regfile writes pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_commit;

  localparam int DEPTH = 8;
  localparam int TAGW  = 3;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            flush_in;
  logic            alloc_valid;
  logic [4:0]      alloc_rd;
  logic            alloc_ready;
  logic [TAGW-1:0] alloc_tag;
  logic            cmpl_valid;
  logic [TAGW-1:0] cmpl_tag;
  logic [31:0]     cmpl_data;
  logic            write_or_not;
  logic [4:0]      writeaddr;
  logic [31:0]     writedata;
  logic [TAGW:0]   count_out;
  logic            empty_out;

  rob_commit #(.DEPTH(DEPTH), .TAGW(TAGW)) u_dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .flush_in    (flush_in),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .cmpl_valid  (cmpl_valid),
    .cmpl_tag    (cmpl_tag),
    .cmpl_data   (cmpl_data),
    .write_or_not(write_or_not),
    .writeaddr   (writeaddr),
    .writedata   (writedata),
    .count_out   (count_out),
    .empty_out   (empty_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;

  typedef struct {
    logic [TAGW-1:0] tag;
    logic [4:0]      rd;
    logic            done;
    logic [31:0]     data;
  } sb_entry_t;

  sb_entry_t       sb[$];
  logic [TAGW-1:0] m_tail = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare writes first, then absorb this cycle's stimulus.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      sb.delete();
      m_tail = '0;
    end else begin
      if (write_or_not) begin
        sb_entry_t e;
        n_writes++;
        while (sb.size() > 0 && sb[0].rd == 5'd0 && sb[0].done) void'(sb.pop_front());
        check("write_pending", (sb.size() > 0), 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("commit_done", e.done, 1'b1);
          check("commit_addr", writeaddr, e.rd);
          check("commit_data", writedata, e.data);
        end
      end
      if (flush_in) begin
        sb.delete();
        m_tail = '0;
      end else begin
        if (cmpl_valid) begin
          for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].tag == cmpl_tag) begin
              if (!sb[i].done) begin
                sb[i].done = 1'b1;
                sb[i].data = cmpl_data;
              end
              break;
            end
          end
        end
        if (alloc_valid && alloc_ready) begin
          check("alloc_tag", alloc_tag, m_tail);
          for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].tag == m_tail) begin
              check("tag_reuse_retired", (sb[i].rd == 5'd0 && sb[i].done), 1'b1);
              sb.delete(i);
            end
          end
          sb.push_back('{tag: m_tail, rd: alloc_rd, done: 1'b0, data: 32'h0});
          m_tail = m_tail + TAGW'(1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in      = 1'b0;
    flush_in    = 1'b0;
    alloc_valid = 1'b0;
    cmpl_valid  = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
  endtask

  task automatic alloc(input logic [4:0] rd);
    alloc_valid = 1'b1;
    alloc_rd    = rd;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic cmpl(input logic [TAGW-1:0] tag, input logic [31:0] data);
    cmpl_valid = 1'b1;
    cmpl_tag   = tag;
    cmpl_data  = data;
    tick();
    cmpl_valid = 1'b0;
  endtask

  initial begin
    int w0;
    rst_in      = 1'b0;
    flush_in    = 1'b0;
    alloc_valid = 1'b0;
    alloc_rd    = '0;
    cmpl_valid  = 1'b0;
    cmpl_tag    = '0;
    cmpl_data   = '0;
    do_reset();

    // Reset then idle
    check("rst_waddr", writeaddr, 5'd0);
    check("rst_wdata", writedata, 32'd0);
    repeat (10) begin
      check("idle_ready", alloc_ready, 1'b1);
      check("idle_tag", alloc_tag, 3'd0);
      check("idle_empty", empty_out, 1'b1);
      check("idle_wen", write_or_not, 1'b0);
      tick();
    end

    // In-order commit despite out-of-order completion
    do_reset();
    alloc(5'd5);
    alloc(5'd6);
    alloc(5'd7);
    check("ooo_count", count_out, 4'd3);
    cmpl(3'd2, 32'h33);
    check("ooo_wen_a1", write_or_not, 1'b0);
    cmpl(3'd0, 32'h11);
    check("ooo_wen_a2", write_or_not, 1'b0);
    cmpl(3'd1, 32'h22);
    check("ooo_w1_en", write_or_not, 1'b1);
    check("ooo_w1_addr", writeaddr, 5'd5);
    check("ooo_w1_data", writedata, 32'h11);
    tick();
    check("ooo_w2_en", write_or_not, 1'b1);
    check("ooo_w2_addr", writeaddr, 5'd6);
    check("ooo_w2_data", writedata, 32'h22);
    tick();
    check("ooo_w3_en", write_or_not, 1'b1);
    check("ooo_w3_addr", writeaddr, 5'd7);
    check("ooo_w3_data", writedata, 32'h33);
    tick();
    check("ooo_after_wen", write_or_not, 1'b0);
    check("ooo_after_empty", empty_out, 1'b1);
    check("ooo_sb_drained", sb.size(), 0);

    // Full and wrap
    do_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_rd = 5'(i + 1);
      tick();
    end
    check("full_ready", alloc_ready, 1'b0);
    check("full_count", count_out, 4'd8);
    check("full_tail", alloc_tag, 3'd0);
    w0 = n_writes;
    for (int k = 0; k < 28; k++) begin
      cmpl_valid = 1'b1;
      cmpl_tag   = 3'(k);
      cmpl_data  = 32'h1000 + 32'(k);
      alloc_rd   = 5'((k % 30) + 1);
      tick();
      if (k == 0) check("full_hold_ready", alloc_ready, 1'b0);
      if (k == 1) begin
        check("refill_ready", alloc_ready, 1'b1);
        check("refill_tag", alloc_tag, 3'd0);
        check("refill_count", count_out, 4'd7);
      end
    end
    alloc_valid = 1'b0;
    cmpl_valid  = 1'b0;
    repeat (4) tick();
    check("wrap_writes", n_writes - w0, 28);
    check("wrap_count", count_out, 4'd6);

    // x0 destination
    do_reset();
    alloc(5'd0);
    check("x0_count_alloc", count_out, 4'd1);
    cmpl(3'd0, 32'hDEADBEEF);
    check("x0_count_pending", count_out, 4'd1);
    check("x0_wen_a1", write_or_not, 1'b0);
    tick();
    check("x0_count_retired", count_out, 4'd0);
    check("x0_empty", empty_out, 1'b1);
    check("x0_wen_a2", write_or_not, 1'b0);
    tick();
    check("x0_wen_a3", write_or_not, 1'b0);

    // Stray and duplicate completion
    do_reset();
    cmpl(3'd4, 32'h44);
    check("stray_count", count_out, 4'd0);
    check("stray_empty", empty_out, 1'b1);
    tick();
    check("stray_wen", write_or_not, 1'b0);
    alloc(5'd9);
    check("dup_count", count_out, 4'd1);
    cmpl(3'd0, 32'hAA);
    cmpl(3'd0, 32'hBB);
    check("dup_wen", write_or_not, 1'b1);
    check("dup_addr", writeaddr, 5'd9);
    check("dup_data", writedata, 32'hAA);

    // Flush with in-flight work and same-cycle stimulus
    do_reset();
    for (int i = 0; i < 5; i++) alloc(5'(10 + i));
    cmpl(3'd3, 32'h333);
    cmpl(3'd4, 32'h444);
    check("preflush_count", count_out, 4'd5);
    flush_in    = 1'b1;
    alloc_valid = 1'b1;
    alloc_rd    = 5'd1;
    cmpl_valid  = 1'b1;
    cmpl_tag    = 3'd2;
    cmpl_data   = 32'h222;
    tick();
    flush_in    = 1'b0;
    alloc_valid = 1'b0;
    cmpl_valid  = 1'b0;
    check("flush_count", count_out, 4'd0);
    check("flush_empty", empty_out, 1'b1);
    check("flush_tag", alloc_tag, 3'd0);
    check("flush_ready", alloc_ready, 1'b1);
    repeat (4) begin
      check("flush_no_commit", write_or_not, 1'b0);
      tick();
    end

    // Asynchronous reset mid-operation
    do_reset();
    for (int i = 0; i < 5; i++) alloc(5'(10 + i));
    cmpl(3'd0, 32'h55);
    cmpl(3'd1, 32'h66);
    check("prerst_wen", write_or_not, 1'b1);
    check("prerst_data", writedata, 32'h55);
    #2;
    rst_in = 1'b0;
    #1;
    check("arst_wen", write_or_not, 1'b0);
    check("arst_waddr", writeaddr, 5'd0);
    check("arst_wdata", writedata, 32'd0);
    check("arst_count", count_out, 4'd0);
    check("arst_empty", empty_out, 1'b1);
    check("arst_tag", alloc_tag, 3'd0);
    tick();
    rst_in = 1'b1;
    tick();
    check("postrst_wen", write_or_not, 1'b0);
    check("postrst_count", count_out, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
